// File: rtl/axil_apb_bridge_pkg.sv
// Shared types and constants for the AXI-Lite to APB4 bridge.
// Holds the bridge states, the AXI response codes and the timeout counter sizing.
package axil_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    BRESP,
    RRESP
  } bridge_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A disabled timeout (0 cycles) still needs a legal one-bit counter.
  function automatic int timeout_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/axil_apb_bridge_if.sv
// Bus bundles for the bridge: an AXI4-Lite port and an APB4 port.
// Each bundle has a master view and a slave view.
interface axil_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/axil_apb_bridge_timer.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles and flags the cycle
// in which the TIMEOUT_CYCLES-th stall occurs. TIMEOUT_CYCLES = 0 never expires.
module apb_timeout_timer
  import axil_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam int LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

  logic [CNT_W-1:0] count;

  // Saturates so a disabled or already-fired timer can never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST_CNT);

endmodule

// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge: one transaction in flight, round-robin
// between reads and writes, with an ACCESS-phase timeout for hung peripherals.
module axil_apb_bridge
  import axil_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic   clk,
  input logic   rst,
  axil_if.slave s_axil,
  apb_if.master m_apb
);

  bridge_state_e state, state_next;

  logic                  prefer_read;
  logic                  write_ok, read_ok;
  logic                  grant_write, grant_read;
  logic                  timer_clear, timer_enable, timer_expired;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [2:0]            pprot_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;

  assign write_ok = s_axil.awvalid && s_axil.wvalid;
  assign read_ok  = s_axil.arvalid;

  // Grants are only given in IDLE; on contention the class not served last wins.
  always_comb begin
    state_next  = state;
    grant_write = 1'b0;
    grant_read  = 1'b0;
    case (state)
      IDLE: begin
        if (write_ok && read_ok) begin
          grant_write = !prefer_read;
          grant_read  = prefer_read;
        end else begin
          grant_write = write_ok;
          grant_read  = read_ok;
        end
        if (write_ok || read_ok) state_next = SETUP;
      end
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (m_apb.pready || timer_expired) state_next = pwrite_q ? BRESP : RRESP;
      end
      BRESP:   if (s_axil.bready) state_next = IDLE;
      RRESP:   if (s_axil.rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             prefer_read <= 1'b0;
    else if (grant_write) prefer_read <= 1'b1;
    else if (grant_read)  prefer_read <= 1'b0;
  end

  // Request fields are frozen at grant so they stay stable through ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (grant_write) begin
      paddr_q  <= {s_axil.awaddr[ADDR_WIDTH-1:2], 2'b00};
      pprot_q  <= s_axil.awprot;
      pwrite_q <= 1'b1;
      pwdata_q <= s_axil.wdata;
      pstrb_q  <= s_axil.wstrb;
    end else if (grant_read) begin
      paddr_q  <= {s_axil.araddr[ADDR_WIDTH-1:2], 2'b00};
      pprot_q  <= s_axil.arprot;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
    end
  end

  // A real completion takes priority over a timeout firing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q  <= RESP_OKAY;
      rdata_q <= '0;
    end else if ((state == ACCESS) && m_apb.pready) begin
      resp_q <= m_apb.pslverr ? RESP_SLVERR : RESP_OKAY;
      if (!pwrite_q) rdata_q <= m_apb.prdata;
    end else if (timer_expired) begin
      resp_q <= RESP_SLVERR;
      if (!pwrite_q) rdata_q <= '0;
    end
  end

  assign timer_clear  = (state == SETUP);
  assign timer_enable = (state == ACCESS) && !m_apb.pready;

  apb_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  assign s_axil.awready = grant_write;
  assign s_axil.wready  = grant_write;
  assign s_axil.arready = grant_read;
  assign s_axil.bvalid  = (state == BRESP);
  assign s_axil.rvalid  = (state == RRESP);
  assign s_axil.bresp   = resp_q;
  assign s_axil.rresp   = resp_q;
  assign s_axil.rdata   = rdata_q;

  assign m_apb.psel    = (state == SETUP) || (state == ACCESS);
  assign m_apb.penable = (state == ACCESS);
  assign m_apb.paddr   = paddr_q;
  assign m_apb.pprot   = pprot_q;
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.pwdata  = pwdata_q;
  assign m_apb.pstrb   = pstrb_q;

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Self-checking bench for axil_apb_bridge: directed scenarios plus a randomized
// stream checked against a transaction-level model of the bridge.
module tb_axil_apb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axil();
  apb_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_apb();

  axil_apb_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .s_axil(s_axil), .m_apb(m_apb)
  );

  int vectors = 0;
  int miscompares = 0;

  // APB peripheral: holds pready low for apb_wait ACCESS cycles (negative = forever).
  int          apb_wait = 0;
  bit          apb_err = 1'b0;
  logic [31:0] apb_rdata = '0;
  int          acc_cnt = 0;
  always @(negedge clk) begin
    if (m_apb.psel && m_apb.penable) begin
      m_apb.pready = (apb_wait >= 0) && (acc_cnt >= apb_wait);
      acc_cnt++;
    end else begin
      m_apb.pready = 1'b0;
      acc_cnt = 0;
    end
    m_apb.pslverr = apb_err;
    m_apb.prdata  = apb_rdata;
  end

  // APB monitor: records each SETUP and checks the request is held through ACCESS.
  logic [31:0] cap_paddr, cap_pwdata;
  logic [3:0]  cap_pstrb;
  logic [2:0]  cap_pprot;
  logic        cap_pwrite;
  int          setup_count = 0, access_cycles = 0, stable_err = 0;
  bit          grant_q[$];
  always @(negedge clk) begin
    if (m_apb.psel && !m_apb.penable) begin
      cap_paddr = m_apb.paddr; cap_pwdata = m_apb.pwdata; cap_pstrb = m_apb.pstrb;
      cap_pprot = m_apb.pprot; cap_pwrite = m_apb.pwrite;
      setup_count++; access_cycles = 0; grant_q.push_back(m_apb.pwrite);
    end else if (m_apb.psel && m_apb.penable) begin
      access_cycles++;
      if (m_apb.paddr !== cap_paddr || m_apb.pwdata !== cap_pwdata || m_apb.pstrb !== cap_pstrb ||
          m_apb.pprot !== cap_pprot || m_apb.pwrite !== cap_pwrite) stable_err++;
    end
  end

  logic [31:0] last_wdata = '0;
  bit          last_grant_write = 1'b0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot, input int wait_c,
                         input bit err, input logic [31:0] prd,
                         output logic [1:0] resp, output logic [31:0] rdata, output int lat);
    int guard;
    apb_wait = wait_c; apb_err = err; apb_rdata = prd;
    tick();
    if (is_wr) begin
      s_axil.awaddr = addr; s_axil.awprot = prot; s_axil.wdata = data; s_axil.wstrb = strb;
      s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1;
    end else begin
      s_axil.araddr = addr; s_axil.arprot = prot; s_axil.arvalid = 1'b1;
    end
    #1;
    guard = 0;
    while (!(is_wr ? s_axil.awready : s_axil.arready) && guard < 50) begin
      tick(); #1; guard++;
    end
    if (guard >= 50) begin
      miscompares++;
      $display("[TB] FAIL handshake: no ready after %0d cycles, required within 50", guard);
    end
    vectors++;
    @(posedge clk);
    tick();
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0; s_axil.arvalid = 1'b0;
    s_axil.bready = 1'b1; s_axil.rready = 1'b1;
    lat = 1;
    while (!(is_wr ? s_axil.bvalid : s_axil.rvalid) && lat < 40) begin
      tick(); lat++;
    end
    resp = is_wr ? s_axil.bresp : s_axil.rresp;
    rdata = s_axil.rdata;
    last_grant_write = is_wr;
    @(posedge clk);
    tick();
    s_axil.bready = 1'b0; s_axil.rready = 1'b0;
  endtask

  task automatic test_reset();
    s_axil.awaddr = '0; s_axil.awprot = '0; s_axil.awvalid = 0; s_axil.wdata = '0;
    s_axil.wstrb = '0; s_axil.wvalid = 0; s_axil.bready = 0; s_axil.araddr = '0;
    s_axil.arprot = '0; s_axil.arvalid = 0; s_axil.rready = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    if ({s_axil.awready, s_axil.wready, s_axil.arready, s_axil.bvalid, s_axil.rvalid} !== 5'b0) begin
      miscompares++; $display("[TB] FAIL reset_axil_ctrl: got %b required 00000",
        {s_axil.awready, s_axil.wready, s_axil.arready, s_axil.bvalid, s_axil.rvalid});
    end
    vectors++;
    if ({m_apb.psel, m_apb.penable, m_apb.pwrite} !== 3'b0) begin
      miscompares++; $display("[TB] FAIL reset_apb_ctrl: got %b required 000",
        {m_apb.psel, m_apb.penable, m_apb.pwrite});
    end
    vectors++;
    if ({m_apb.paddr, m_apb.pwdata, m_apb.pstrb, m_apb.pprot} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_apb_data: paddr %h pwdata %h pstrb %h pprot %h, required all 0",
        m_apb.paddr, m_apb.pwdata, m_apb.pstrb, m_apb.pprot);
    end
    vectors++;
    if ({s_axil.rdata, s_axil.bresp, s_axil.rresp} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_resp: rdata %h bresp %b rresp %b, required all 0",
        s_axil.rdata, s_axil.bresp, s_axil.rresp);
    end
    vectors++;
    rst = 1'b1;
    last_grant_write = 1'b0;
    last_wdata = '0;
  endtask

  task automatic test_arbitration();
    int handshakes = 0, responses = 0, guard = 0, s0;
    bit exp_wr;
    grant_q.delete();
    s0 = setup_count;
    apb_wait = 0; apb_err = 0;
    tick();
    s_axil.awaddr = 32'h100; s_axil.wdata = 32'h1111_2222; s_axil.wstrb = 4'hF;
    s_axil.araddr = 32'h200; s_axil.awvalid = 1; s_axil.wvalid = 1; s_axil.arvalid = 1;
    s_axil.bready = 1; s_axil.rready = 1;
    while (responses < 4 && guard < 100) begin
      if (handshakes >= 4) begin
        s_axil.awvalid = 0; s_axil.wvalid = 0; s_axil.arvalid = 0;
      end
      #1;
      if (s_axil.awvalid && s_axil.awready) handshakes++;
      if (s_axil.arvalid && s_axil.arready) handshakes++;
      if (s_axil.bvalid || s_axil.rvalid) responses++;
      tick(); guard++;
    end
    s_axil.awvalid = 0; s_axil.wvalid = 0; s_axil.arvalid = 0;
    s_axil.bready = 0; s_axil.rready = 0;
    if (responses != 4 || setup_count - s0 != 4) begin
      miscompares++; $display("[TB] FAIL arb_count: responses %0d bursts %0d, required 4 and 4",
        responses, setup_count - s0);
    end
    vectors++;
    exp_wr = !last_grant_write;
    for (int i = 0; i < 4; i++) begin
      if (grant_q.size() <= i || grant_q[i] !== exp_wr) begin
        miscompares++; $display("[TB] FAIL arb_order[%0d]: got pwrite %b required %b", i,
          (grant_q.size() > i) ? grant_q[i] : 1'bx, exp_wr);
      end
      vectors++;
      exp_wr = !exp_wr;
    end
    last_grant_write = !exp_wr;
    last_wdata = 32'h1111_2222;
  endtask

  task automatic test_lone_valid();
    int bad = 0;
    tick();
    s_axil.awvalid = 1; s_axil.wvalid = 0;
    repeat (5) begin
      #1; if (s_axil.awready !== 0 || s_axil.wready !== 0 || m_apb.psel !== 0) bad++;
      tick();
    end
    s_axil.awvalid = 0; s_axil.wvalid = 1;
    repeat (5) begin
      #1; if (s_axil.awready !== 0 || s_axil.wready !== 0 || m_apb.psel !== 0) bad++;
      tick();
    end
    s_axil.wvalid = 0;
    if (bad != 0) begin
      miscompares++; $display("[TB] FAIL lone_valid: %0d accepting cycles, required 0", bad);
    end
    vectors++;
  endtask

  task automatic test_write_latency();
    logic [1:0] resp; logic [31:0] rd; int lat;
    run_txn(1, 32'h1006, 32'hA5A5_A5A5, 4'b0011, 3'b010, 0, 0, 32'h0, resp, rd, lat);
    if (cap_paddr !== 32'h1004 || cap_pstrb !== 4'b0011 || cap_pwrite !== 1'b1 || cap_pwdata !== 32'hA5A5_A5A5) begin
      miscompares++; $display("[TB] FAIL wr_setup: paddr %h pstrb %b pwrite %b pwdata %h, required 1004 0011 1 a5a5a5a5",
        cap_paddr, cap_pstrb, cap_pwrite, cap_pwdata);
    end
    vectors++;
    if (lat != 3 || access_cycles != 1) begin
      miscompares++; $display("[TB] FAIL wr_latency: valid at %0d access %0d, required 3 and 1", lat, access_cycles);
    end
    vectors++;
    if (resp !== 2'b00) begin
      miscompares++; $display("[TB] FAIL wr_bresp: got %b required 00", resp);
    end
    vectors++;
    last_wdata = 32'hA5A5_A5A5;
  endtask

  task automatic test_read_wait_slverr();
    logic [1:0] resp; logic [31:0] rd; int lat; int se0;
    se0 = stable_err;
    run_txn(0, 32'h2000, 32'h0, 4'h0, 3'b101, 3, 1, 32'h1234_5678, resp, rd, lat);
    if (rd !== 32'h1234_5678 || resp !== 2'b10) begin
      miscompares++; $display("[TB] FAIL rd_slverr: rdata %h rresp %b, required 12345678 10", rd, resp);
    end
    vectors++;
    if (cap_paddr !== 32'h2000 || cap_pwrite !== 0 || cap_pstrb !== 0 || cap_pwdata !== last_wdata ||
        stable_err != se0) begin
      miscompares++; $display("[TB] FAIL rd_apb: paddr %h pwrite %b pstrb %b pwdata %h unstable %0d, required 2000 0 0 %h 0",
        cap_paddr, cap_pwrite, cap_pstrb, cap_pwdata, stable_err - se0, last_wdata);
    end
    vectors++;
    if (lat != 6 || access_cycles != 4) begin
      miscompares++; $display("[TB] FAIL rd_wait: valid at %0d access %0d, required 6 and 4", lat, access_cycles);
    end
    vectors++;
  endtask

  task automatic test_timeout();
    logic [1:0] resp; logic [31:0] rd; int lat;
    run_txn(0, 32'h3000, 32'h0, 4'h0, 3'b000, -1, 0, 32'hDEAD_BEEF, resp, rd, lat);
    if (resp !== 2'b10 || rd !== 32'h0 || access_cycles != TO || lat != 10) begin
      miscompares++; $display("[TB] FAIL timeout: rresp %b rdata %h access %0d valid at %0d, required 10 0 %0d 10",
        resp, rd, access_cycles, lat, TO);
    end
    vectors++;
    run_txn(0, 32'h3004, 32'h0, 4'h0, 3'b000, TO - 1, 0, 32'hBEEF_0001, resp, rd, lat);
    if (resp !== 2'b00 || rd !== 32'hBEEF_0001 || access_cycles != TO || lat != 10) begin
      miscompares++; $display("[TB] FAIL timeout_race: rresp %b rdata %h access %0d valid at %0d, required 00 beef0001 %0d 10",
        resp, rd, access_cycles, lat, TO);
    end
    vectors++;
  endtask

  task automatic test_backpressure();
    int bad = 0, g = 0;
    apb_wait = 0; apb_err = 0;
    tick();
    s_axil.awaddr = 32'h5000; s_axil.wdata = 32'h5555_AAAA; s_axil.wstrb = 4'hF;
    s_axil.awvalid = 1; s_axil.wvalid = 1; s_axil.bready = 0;
    #1;
    if (s_axil.awready !== 1) bad++;
    @(posedge clk);
    tick();
    s_axil.awvalid = 0; s_axil.wvalid = 0;
    s_axil.araddr = 32'h6000; s_axil.arprot = 3'b000; s_axil.arvalid = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (s_axil.arready !== 0) bad++;
      if (i >= 2 && (m_apb.psel !== 0 || s_axil.bvalid !== 1)) bad++;
      tick();
    end
    s_axil.bready = 1;
    #1;
    if (s_axil.arready !== 0) bad++;
    if (bad != 0) begin
      miscompares++; $display("[TB] FAIL bp_hold: %0d bad cycles, required 0", bad);
    end
    vectors++;
    @(posedge clk);
    tick();
    s_axil.bready = 0;
    #1;
    if (s_axil.arready !== 1) begin
      miscompares++; $display("[TB] FAIL bp_regrant: arready %b required 1", s_axil.arready);
    end
    vectors++;
    @(posedge clk);
    tick();
    s_axil.arvalid = 0; s_axil.rready = 1;
    while (!s_axil.rvalid && g < 20) begin
      tick(); g++;
    end
    if (s_axil.rvalid !== 1) begin
      miscompares++; $display("[TB] FAIL bp_read: rvalid %b required 1", s_axil.rvalid);
    end
    vectors++;
    @(posedge clk);
    tick();
    s_axil.rready = 0;
    last_wdata = 32'h5555_AAAA;
    last_grant_write = 0;
  endtask

  task automatic test_reset_mid_access();
    logic [1:0] resp; logic [31:0] rd; int lat; int seen = 0;
    apb_wait = -1;
    tick();
    s_axil.awaddr = 32'h7000; s_axil.wdata = 32'h0000_0077; s_axil.wstrb = 4'hF;
    s_axil.awvalid = 1; s_axil.wvalid = 1;
    @(posedge clk);
    tick();
    s_axil.awvalid = 0; s_axil.wvalid = 0; s_axil.bready = 1;
    tick();
    if (m_apb.penable !== 1) begin
      miscompares++; $display("[TB] FAIL rstmid_access: penable %b required 1", m_apb.penable);
    end
    vectors++;
    #2 rst = 1'b0;
    #1;
    if ({m_apb.psel, m_apb.penable, s_axil.bvalid} !== 3'b000) begin
      miscompares++; $display("[TB] FAIL rstmid_drop: psel/penable/bvalid %b required 000",
        {m_apb.psel, m_apb.penable, s_axil.bvalid});
    end
    vectors++;
    tick(); tick();
    rst = 1'b1;
    apb_wait = 0;
    repeat (5) begin
      tick();
      if (s_axil.bvalid || m_apb.psel) seen++;
    end
    s_axil.bready = 0;
    if (seen != 0) begin
      miscompares++; $display("[TB] FAIL rstmid_noresp: %0d active cycles, required 0", seen);
    end
    vectors++;
    last_wdata = '0;
    run_txn(1, 32'h4008, 32'hCAFE_F00D, 4'hF, 3'b001, 0, 0, 32'h0, resp, rd, lat);
    if (resp !== 2'b00 || lat != 3 || cap_paddr !== 32'h4008 || cap_pwdata !== 32'hCAFE_F00D) begin
      miscompares++; $display("[TB] FAIL rstmid_recover: bresp %b valid at %0d paddr %h pwdata %h, required 00 3 4008 cafef00d",
        resp, lat, cap_paddr, cap_pwdata);
    end
    vectors++;
    last_wdata = 32'hCAFE_F00D;
  endtask

  task automatic test_random();
    logic [1:0] resp, exp_resp; logic [31:0] rd, exp_rd, addr, data, prd, exp_wd;
    logic [3:0] strb; logic [2:0] prot; int lat, w, exp_lat, exp_acc, se0; bit is_wr, err, timed_out;
    se0 = stable_err;
    for (int n = 0; n < 24; n++) begin
      is_wr = 1'($urandom_range(0, 1)); addr = $urandom; data = $urandom; prd = $urandom;
      strb = 4'($urandom_range(0, 15)); prot = 3'($urandom_range(0, 7));
      w = $urandom_range(0, 9); err = 1'($urandom_range(0, 1));
      run_txn(is_wr, addr, data, strb, prot, w, err, prd, resp, rd, lat);
      timed_out = (w >= TO);
      exp_resp = (timed_out || err) ? 2'b10 : 2'b00;
      exp_lat = 3 + (timed_out ? TO - 1 : w);
      exp_acc = timed_out ? TO : w + 1;
      exp_rd = timed_out ? 32'h0 : prd;
      exp_wd = is_wr ? data : last_wdata;
      if (resp !== exp_resp || lat != exp_lat || access_cycles != exp_acc) begin
        miscompares++; $display("[TB] FAIL rand%0d_resp: resp %b valid at %0d access %0d, required %b %0d %0d",
          n, resp, lat, access_cycles, exp_resp, exp_lat, exp_acc);
      end
      vectors++;
      if (!is_wr) begin
        if (rd !== exp_rd) begin
          miscompares++; $display("[TB] FAIL rand%0d_rdata: got %h required %h", n, rd, exp_rd);
        end
        vectors++;
      end
      if (cap_paddr !== {addr[31:2], 2'b00} || cap_pwrite !== is_wr || cap_pstrb !== (is_wr ? strb : 4'h0) ||
          cap_pprot !== prot || cap_pwdata !== exp_wd) begin
        miscompares++; $display("[TB] FAIL rand%0d_apb: paddr %h pwrite %b pstrb %b pprot %b pwdata %h, required %h %b %b %b %h",
          n, cap_paddr, cap_pwrite, cap_pstrb, cap_pprot, cap_pwdata,
          {addr[31:2], 2'b00}, is_wr, is_wr ? strb : 4'h0, prot, exp_wd);
      end
      vectors++;
      if (is_wr) last_wdata = data;
    end
    if (stable_err != se0) begin
      miscompares++; $display("[TB] FAIL rand_stable: %0d unstable ACCESS cycles, required 0", stable_err - se0);
    end
    vectors++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_arbitration();
    test_lone_valid();
    test_write_latency();
    test_read_wait_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_apb_bridge.md
Name: axil_apb_bridge

Overview:
- Downstream stage of the AXI4-to-AXI4-Lite bridge. Accepts its AXI-Lite master traffic and turns each transaction into one APB4 transfer (SETUP then ACCESS).
- Only one transaction is in flight at a time. When reads and writes contend, a two-way round-robin picks between them.
- A programmable ACCESS-phase timeout protects the interconnect from a hung APB peripheral.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width on both sides; must be 32 (APB limit).
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles before forced termination; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  write protection
- s_axil_awvalid/s_axil_awready  in/out  1  write address handshake
- s_axil_wdata  in  DATA_WIDTH  write data
- s_axil_wstrb  in  STRB_WIDTH  write strobes
- s_axil_wvalid/s_axil_wready  in/out  1  write data handshake
- s_axil_bresp  out  2  write response
- s_axil_bvalid/s_axil_bready  out/in  1  write response handshake
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  read protection
- s_axil_arvalid/s_axil_arready  in/out  1  read address handshake
- s_axil_rdata  out  DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid/s_axil_rready  out/in  1  read data handshake
- m_apb_paddr  out  ADDR_WIDTH  APB address
- m_apb_pprot  out  3  APB protection
- m_apb_psel, m_apb_penable, m_apb_pwrite  out  1  APB control
- m_apb_pwdata  out  DATA_WIDTH  APB write data
- m_apb_pstrb  out  STRB_WIDTH  APB write strobes
- m_apb_pready, m_apb_pslverr  in  1  APB completion and error
- m_apb_prdata  in  DATA_WIDTH  APB read data

Behaviour:
- States: IDLE, SETUP, ACCESS, BRESP, RRESP.
- Reset values: all ready/valid, psel, penable, pwrite outputs 0; paddr, pwdata, pstrb, pprot, rdata, bresp, rresp 0; state IDLE; arbitration pointer favours write.
- Reset mid-operation: psel, penable and bvalid/rvalid drop asynchronously; no response is issued for the aborted transaction.
- IDLE, write eligibility: awvalid && wvalid together. Read eligibility: arvalid.
- IDLE, both eligible: grant the class not granted last. A single eligible class wins outright.
- Granted write: awready and wready are asserted combinationally in the same cycle. awaddr, awprot, wdata and wstrb are captured; pwrite=1. Next state SETUP.
- Granted read: arready is asserted combinationally in the same cycle. araddr and arprot are captured; pwrite=0; pstrb=0. Next state SETUP.
- Address alignment: paddr = captured address with bits [1:0] forced to 0.
- SETUP (one cycle): psel=1, penable=0. Next state ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite, pwdata, pstrb and pprot are held stable.
- ACCESS, pready=1: psel and penable drop. Response code is 2'b10 (SLVERR) if pslverr=1, else 2'b00 (OKAY). For reads, prdata is latched into rdata. Next state BRESP or RRESP.
- Timeout: a counter clears on SETUP entry and increments each ACCESS cycle without pready. When TIMEOUT_CYCLES is nonzero and the count reaches TIMEOUT_CYCLES, the transfer is terminated. psel and penable drop, the response is SLVERR, and rdata is 0.
- pready arriving on the same cycle the timeout fires: pready wins and the normal response is returned.
- BRESP/RRESP: bvalid or rvalid is held until bready or rready. Outputs are registered, so the earliest response is one cycle after pready.
- Latency with zero-wait APB: handshake at cycle N, SETUP N+1, ACCESS N+2, valid N+3.
- No new AXI-Lite handshake is accepted until the response is accepted. Returning to IDLE then allows a grant in that same cycle.
- A lone awvalid without wvalid, or the reverse, is never accepted.
- pwdata is not changed by reads.

Decomposition:
- Shared package axil_apb_pkg holds:
  - state enum (IDLE/SETUP/ACCESS/BRESP/RRESP);
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - timeout counter width = $clog2(TIMEOUT_CYCLES+1).
- One sub-module, apb_timeout_timer: clear, enable, and an expired flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write awaddr=0x1006, wdata=0xA5A5A5A5, wstrb=4'b0011, pready tied 1 -> paddr=0x1004 and pstrb=0011 in SETUP at N+1; penable at N+2; bvalid with bresp=00 at N+3.
- Read araddr=0x2000, pready low 3 cycles then high with prdata=0x12345678 and pslverr=1 -> rdata=0x12345678, rresp=10; paddr, pwrite=0 and pstrb=0 held through ACCESS.
- awvalid+wvalid and arvalid all held high for 4 transactions -> grant order write, read, write, read; exactly one psel burst each.
- TIMEOUT_CYCLES=8, pready stuck 0 -> psel drops after 8 ACCESS cycles; rvalid with rresp=10 and rdata=0. Repeat with pready arriving on cycle 8 -> OKAY response.
- bready held 0 for 10 cycles while arvalid=1 -> arready stays 0 and psel stays 0 until bready.
- rst pulsed low during ACCESS -> psel, penable and bvalid go 0 immediately; after release, the next write completes normally.
